// File: rtl/ioblock_pkg.sv
// ioblock_pkg: shared config layout and tri-state mux encodings
// for the multi-pin IO bank.
package ioblock_pkg;

  localparam int CFG_BITS_PER_PIN = 4;

  localparam int CFG_DORREG   = 0;
  localparam int CFG_OREG     = 1;
  localparam int CFG_TSMUX_LO = 2;

  localparam logic [1:0] TSM_Z  = 2'b00;
  localparam logic [1:0] TSM_TS = 2'b01;
  localparam logic [1:0] TSM_ON = 2'b10;

  typedef struct packed {
    logic [1:0] tsmux;
    logic       oreg;
    logic       dorreg;
  } pin_cfg_t;

endpackage

// File: rtl/ioblock_cell.sv
// ioblock_cell: one pad - driver mux, output/input data registers.
// IOB_INPUT_SYNC_EN turns the registered input into a 2-flop sync.
module ioblock_cell
  import ioblock_pkg::*;
(
  input  logic     IOCLK,
  input  logic     IORSTN,
  input  pin_cfg_t i_cfg,
  input  logic     i_ts,
  input  logic     i_out,
  output logic     o_in,
  inout  wire      io_pin
);

  logic r_oreg;
  logic r_ireg;
  logic w_oe;
  logic w_dout;

  always_comb begin
    w_oe = 1'b0;
    unique case (i_cfg.tsmux)
      TSM_Z:   w_oe = 1'b0;
      TSM_TS:  w_oe = i_ts;
      default: w_oe = 1'b1;
    endcase
  end

  assign w_dout = i_cfg.oreg ? r_oreg : i_out;
  assign io_pin = w_oe ? w_dout : 1'bz;

  always_ff @(posedge IOCLK or negedge IORSTN) begin
    if (!IORSTN) r_oreg <= 1'b0;
    else         r_oreg <= i_out;
  end

`ifdef IOB_INPUT_SYNC_EN
  logic r_isync;

  always_ff @(posedge IOCLK or negedge IORSTN) begin
    if (!IORSTN) begin
      r_isync <= 1'b0;
      r_ireg  <= 1'b0;
    end else begin
      r_isync <= io_pin;
      r_ireg  <= r_isync;
    end
  end
`else
  always_ff @(posedge IOCLK or negedge IORSTN) begin
    if (!IORSTN) r_ireg <= 1'b0;
    else         r_ireg <= io_pin;
  end
`endif

  assign o_in = i_cfg.dorreg ? r_ireg : io_pin;

endmodule

// File: rtl/ioblock_bank.sv
// ioblock_bank: WIDTH pads plus scan-loaded shadow config with
// atomic, length-checked commit. Optional: IOB_INPUT_SYNC_EN.
module ioblock_bank
  import ioblock_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             IOCLK,
  input  logic             IORSTN,
  inout  wire  [WIDTH-1:0] PIN,
  input  logic [WIDTH-1:0] TS,
  input  logic [WIDTH-1:0] OUT,
  output logic [WIDTH-1:0] IN,
  input  logic             CFG_SI,
  input  logic             CFG_SE,
  input  logic             CFG_UPD,
  output logic             CFG_SO,
  output logic             CFG_ERR
);

  localparam int CBITS = CFG_BITS_PER_PIN * WIDTH;
  localparam int CNT_W = $clog2(4 * WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CBITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CBITS + 1);

  logic [CBITS-1:0] r_shadow;
  logic [CBITS-1:0] r_active;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // Count saturates one past full so an overshift never wraps to valid
  always_ff @(posedge IOCLK or negedge IORSTN) begin
    if (!IORSTN) begin
      r_shadow <= '0;
      r_active <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else if (CFG_SE) begin
      r_shadow <= {CFG_SI, r_shadow[CBITS-1:1]};
      if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 1'b1;
      if (CFG_UPD) r_err <= 1'b1;
    end else if (CFG_UPD) begin
      r_cnt <= '0;
      if (r_cnt == CNT_FULL) r_active <= r_shadow;
      else                   r_err    <= 1'b1;
    end
  end

  assign CFG_SO  = r_shadow[0];
  assign CFG_ERR = r_err;

  for (genvar g = 0; g < WIDTH; g++) begin : g_pin
    pin_cfg_t w_cfg;
    assign w_cfg = pin_cfg_t'(r_active[g*CFG_BITS_PER_PIN +: CFG_BITS_PER_PIN]);

    ioblock_cell u_cell (
      .IOCLK  (IOCLK),
      .IORSTN (IORSTN),
      .i_cfg  (w_cfg),
      .i_ts   (TS[g]),
      .i_out  (OUT[g]),
      .o_in   (IN[g]),
      .io_pin (PIN[g])
    );
  end

endmodule

// File: tb/tb_ioblock_bank.sv
// tb_ioblock_bank: directed vectors for a 2-pin bank; undriven pads
// are pulled low so a released pad reads 0.
module tb_ioblock_bank;

  logic       clk;
  logic       rst_n;
  logic [1:0] ts;
  logic [1:0] dout;
  logic [1:0] din;
  logic       si, se, upd;
  logic       so, err;
  logic [1:0] ext_en;
  logic [1:0] ext_val;
  wire  [1:0] pad;

  int n_vec = 0;
  int n_bad = 0;

  assign pad[0] = ext_en[0] ? ext_val[0] : 1'bz;
  assign pad[1] = ext_en[1] ? ext_val[1] : 1'bz;
  pulldown pd0 (pad[0]);
  pulldown pd1 (pad[1]);

  ioblock_bank #(.WIDTH(2)) dut (
    .IOCLK   (clk),
    .IORSTN  (rst_n),
    .PIN     (pad),
    .TS      (ts),
    .OUT     (dout),
    .IN      (din),
    .CFG_SI  (si),
    .CFG_SE  (se),
    .CFG_UPD (upd),
    .CFG_SO  (so),
    .CFG_ERR (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shift(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      si = v[i];
      se = 1'b1;
      step();
    end
    se = 1'b0;
    si = 1'b0;
  endtask

  task automatic commit();
    upd = 1'b1;
    step();
    upd = 1'b0;
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    ts = 2'b00; dout = 2'b00;
    si = 1'b0; se = 1'b0; upd = 1'b0;
    ext_en = 2'b00; ext_val = 2'b00;
    #1;
    dout = 2'b11;
    #1;
    chk("rst_pad_z", pad, 2'b00);
    chk("rst_so", so, 1'b0);
    chk("rst_err", err, 1'b0);
    release_reset();

    ext_en = 2'b11; ext_val = 2'b10;
    #1;
    chk("rst_in_comb", din, 2'b10);
    chk("rst_pad_ext", pad, 2'b10);
    ext_en = 2'b00;

    shift(16'h0084, 8);
    chk("so_84", so, 1'b0);
    commit();
    chk("tsm_ts_off", pad, 2'b10);
    ts = 2'b01;
    #1;
    chk("tsm_ts_on", pad, 2'b11);
    chk("err_ok", err, 1'b0);
    ts = 2'b00;

    shift(16'h00A4, 8);
    commit();
    dout = 2'b01;
    step();
    chk("oreg_lo", pad[1], 1'b0);
    dout = 2'b11;
    #1;
    chk("oreg_hold", pad[1], 1'b0);
    step();
    chk("oreg_rise", pad[1], 1'b1);

    shift(16'h00A1, 8);
    chk("so_a1", so, 1'b1);
    commit();
    ext_en = 2'b01; ext_val = 2'b00;
    step();
    step();
    ext_val = 2'b01;
    #1;
    chk("ireg_hold", din[0], 1'b0);
    step();
`ifdef IOB_INPUT_SYNC_EN
    chk("isync_e1", din[0], 1'b0);
    step();
    chk("isync_e2", din[0], 1'b1);
`else
    chk("ireg_e1", din[0], 1'b1);
`endif
    ext_en = 2'b00;

    shift(16'h0000, 7);
    si = 1'b0; se = 1'b1; upd = 1'b1;
    step();
    se = 1'b0; upd = 1'b0;
    chk("both_err", err, 1'b1);
    chk("both_keep", pad[1], 1'b1);
    commit();
    chk("both_cnt8", pad, 2'b00);

    async_reset();
    chk("rst2_err", err, 1'b0);
    release_reset();

    shift(16'h0084, 8);
    commit();
    chk("re_84", pad, 2'b10);
    shift(16'h0000, 7);
    commit();
    chk("under_err", err, 1'b1);
    chk("under_keep", pad, 2'b10);
    shift(16'h0000, 9);
    commit();
    chk("over_err", err, 1'b1);
    chk("over_keep", pad, 2'b10);

    shift(16'h00FF, 5);
    async_reset();
    chk("mid_pad_z", pad, 2'b00);
    chk("mid_so", so, 1'b0);
    chk("mid_err", err, 1'b0);
    release_reset();
    shift(16'h0084, 8);
    commit();
    ts = 2'b01;
    #1;
    chk("fresh_pad", pad, 2'b11);
    chk("fresh_err", err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
